// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache; optional hit/miss counters under ICACHE_STAT_EN.
// Latency: hit acks 2 cycles after request; a miss refills the whole line word 0 upward, then acks.
// Backpressure: one request at a time; each MMU read waits for a clean mem_rack low before mem_re rises.
module icache_fetch #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
`ifdef ICACHE_STAT_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_dout,
    output logic        cpu_rack,
    input  logic        inv,
    output logic [31:0] mem_raddr,
    output logic [1:0]  mem_rlen,
    output logic        mem_re,
    input  logic [31:0] mem_din,
    input  logic        mem_rack
);
    localparam int OFF_B = $clog2(WORDS);
    localparam int IDX_B = $clog2(LINES);
    localparam int TAG_B = 30 - OFF_B - IDX_B;
    localparam int OFF_W = (OFF_B > 0) ? OFF_B : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MREQ, S_MACK, S_MDROP, S_RESP} state_t;

    state_t             r_state;
    logic [TAG_B-1:0]   r_tag;
    logic [IDX_B-1:0]   r_idx;
    logic [OFF_W-1:0]   r_off;
    logic [OFF_W-1:0]   r_w;
    logic               r_inv_pend;
    logic [31:0]        r_cpu_dout;
    logic               r_cpu_rack;
    logic [31:0]        r_mem_raddr;
    logic               r_mem_re;
    logic [LINES-1:0]   r_valid;
    logic [TAG_B-1:0]   r_tags [LINES];
    logic [31:0]        r_data [LINES][WORDS];

    logic [29:0]        w_word;
    logic [OFF_W-1:0]   w_off;
    logic [IDX_B-1:0]   w_idx;
    logic [TAG_B-1:0]   w_tag;
    logic               w_hit;
    logic               w_last;
    logic               w_fill_done;
    logic               w_unused_addr;

    assign w_word        = cpu_addr[31:2];
    assign w_off         = (OFF_B == 0) ? '0 : OFF_W'(w_word);
    assign w_idx         = IDX_B'(w_word >> OFF_B);
    assign w_tag         = TAG_B'(w_word >> (OFF_B + IDX_B));
    assign w_unused_addr = ^cpu_addr[1:0];
    assign w_hit         = r_valid[r_idx] && (r_tags[r_idx] == r_tag);
    assign w_last        = (r_w == OFF_W'(WORDS - 1));
    assign w_fill_done   = (r_state == S_MDROP) && !mem_rack && w_last;

    assign cpu_dout  = r_cpu_dout;
    assign cpu_rack  = r_cpu_rack;
    assign mem_raddr = r_mem_raddr;
    assign mem_re    = r_mem_re;
    assign mem_rlen  = 2'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tag       <= '0;
            r_idx       <= '0;
            r_off       <= '0;
            r_w         <= '0;
            r_inv_pend  <= 1'b0;
            r_cpu_dout  <= '0;
            r_cpu_rack  <= 1'b0;
            r_mem_raddr <= '0;
            r_mem_re    <= 1'b0;
        end else begin
            r_cpu_rack <= 1'b0;
            // an invalidate landing mid-refill must keep this line from being installed
            if (inv && r_state != S_IDLE)
                r_inv_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cpu_re && !r_cpu_rack) begin
                        r_tag      <= w_tag;
                        r_idx      <= w_idx;
                        r_off      <= w_off;
                        r_inv_pend <= 1'b0;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_cpu_dout <= r_data[r_idx][r_off];
                        r_cpu_rack <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_w     <= '0;
                        r_state <= S_MREQ;
                    end
                end
                S_MREQ: begin
                    if (!mem_rack) begin
                        r_mem_raddr <= (32'({r_tag, r_idx}) << (OFF_B + 2)) | (32'(r_w) << 2);
                        r_mem_re    <= 1'b1;
                        r_state     <= S_MACK;
                    end
                end
                S_MACK: begin
                    if (mem_rack) begin
                        r_mem_re <= 1'b0;
                        r_state  <= S_MDROP;
                    end
                end
                S_MDROP: begin
                    if (!mem_rack) begin
                        if (w_last) begin
                            r_state <= S_RESP;
                        end else begin
                            r_w     <= r_w + OFF_W'(1);
                            r_state <= S_MREQ;
                        end
                    end
                end
                S_RESP: begin
                    r_cpu_dout <= r_data[r_idx][r_off];
                    r_cpu_rack <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // inv beats a coincident final-fill set
    always_ff @(posedge clk) begin
        if (rst || inv)
            r_valid <= '0;
        else if (w_fill_done && !r_inv_pend)
            r_valid[r_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == S_MACK && mem_rack)
            r_data[r_idx][r_w] <= mem_din;
        if (!rst && w_fill_done)
            r_tags[r_idx] <= r_tag;
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit)
                hit_cnt <= hit_cnt + 32'd1;
            else
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a line-level cache model and an MMU responder.
module tb_icache_fetch;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst, cpu_re, inv, mem_rack, cpu_rack, mem_re;
    logic [31:0] cpu_addr, cpu_dout, mem_raddr, mem_din;
    logic [1:0]  mem_rlen;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int mmu_lat  = 2;
    int hold_extra = 0;
    logic [31:0] rd_q[$];
    logic [31:0] exp_q[$];
    bit          mvalid[LINES];
    logic [23:0] mtag[LINES];
    int m_hits = 0;
    int m_miss = 0;

    always #5 clk = ~clk;

    icache_fetch #(.LINES(LINES), .WORDS(WORDS)) dut (
`ifdef ICACHE_STAT_EN
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt),
`endif
        .clk(clk),
        .rst(rst),
        .cpu_re(cpu_re),
        .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout),
        .cpu_rack(cpu_rack),
        .inv(inv),
        .mem_raddr(mem_raddr),
        .mem_rlen(mem_rlen),
        .mem_re(mem_re),
        .mem_din(mem_din),
        .mem_rack(mem_rack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // MMU responder: level handshake, data = address ^ K, optional stretched rack
    initial begin
        mem_rack = 1'b0;
        mem_din  = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_re && !mem_rack) begin
                rd_q.push_back(mem_raddr);
                repeat (mmu_lat) @(posedge clk);
                #1;
                mem_din  = mem_raddr ^ K;
                mem_rack = 1'b1;
                for (int i = 0; i < 1000 && mem_re; i++) begin
                    @(posedge clk); #1;
                end
                repeat (hold_extra) begin
                    @(posedge clk); #1;
                end
                mem_rack = 1'b0;
            end
        end
    end

    // per-cycle checks of output protocol against the expected-data queue
    logic prev_re = 1'b0, prev_rack = 1'b0, prev_cpu_rack = 1'b0;
    always @(negedge clk) begin
        check("mem_rlen", 32'(mem_rlen), 32'd3);
        if (mem_re && !prev_re)
            check("re_rise_with_rack_high", 32'(prev_rack), 32'd0);
        if (cpu_rack) begin
            check("rack_single_pulse", 32'(prev_cpu_rack), 32'd0);
            check("rack_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check("cpu_dout", cpu_dout, exp_q.pop_front());
        end
        prev_re       = mem_re;
        prev_rack     = mem_rack;
        prev_cpu_rack = cpu_rack;
    end

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input bit inv_mid);
        logic [3:0]  idx;
        logic [31:0] base;
        bit          hit;
        bit          inv_done;
        int          n;
        idx      = addr[7:4];
        base     = {addr[31:4], 4'h0};
        hit      = mvalid[idx] && (mtag[idx] == addr[31:8]);
        inv_done = 1'b0;
        check("model_hit", 32'(hit), 32'(exp_hit));
        exp_q.push_back({addr[31:2], 2'b00} ^ K);
        rd_q.delete();
        cpu_addr = addr;
        cpu_re   = 1'b1;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (inv) inv = 1'b0;
            if (inv_mid && !inv_done && rd_q.size() >= 3) begin
                inv = 1'b1;
                inv_done = 1'b1;
                clear_model();
            end
            if (cpu_rack) break;
        end
        check("fetch_acked", 32'(cpu_rack), 32'd1);
        cpu_re = 1'b0;
        inv    = 1'b0;
        if (hit) begin
            check("hit_latency", 32'(n), 32'd2);
            check("hit_no_mmu", 32'(rd_q.size()), 32'd0);
            m_hits++;
        end else begin
            check("miss_reads", 32'(rd_q.size()), 32'(WORDS));
            for (int i = 0; i < WORDS; i++)
                check("miss_raddr", rd_q[i], base + 32'(4 * i));
            m_miss++;
            if (!inv_done) begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = addr[31:8];
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_re = 1'b0; cpu_addr = '0; inv = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_dout", cpu_dout, 32'd0);
        check("rst_cpu_rack", 32'(cpu_rack), 32'd0);
        check("rst_mem_raddr", mem_raddr, 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
`ifdef ICACHE_STAT_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // cold miss then hit in the same line
        fetch(32'h0000_0104, 1'b0, 1'b0);
        check("cold_dout", cpu_dout, 32'hA5A5_A4A1);
        check("cold_rd0", rd_q[0], 32'h0000_0100);
        check("cold_rd3", rd_q[3], 32'h0000_010C);
        fetch(32'h0000_010C, 1'b1, 1'b0);
        check("hit_dout", cpu_dout, 32'hA5A5_A4A9);

        // idle invalidate, then conflict eviction on index 0
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        clear_model();
        fetch(32'h0000_0100, 1'b0, 1'b0);
        fetch(32'h0000_0500, 1'b0, 1'b0);
        check("evict_rd0", rd_q[0], 32'h0000_0500);
        fetch(32'h0000_0100, 1'b0, 1'b0);
        fetch(32'h0000_0104, 1'b1, 1'b0);

        // stretched mem_rack between words
        hold_extra = 3;
        fetch(32'h0000_0300, 1'b0, 1'b0);
        fetch(32'h0000_0304, 1'b1, 1'b0);
        hold_extra = 0;

        // invalidate after the second fill word
        fetch(32'h0000_0708, 1'b0, 1'b1);
        check("inv_mid_dout", cpu_dout, 32'hA5A5_A2AD);
        fetch(32'h0000_0708, 1'b0, 1'b0);
        fetch(32'h0000_0700, 1'b1, 1'b0);

        // reset while waiting for mem_rack
        mmu_lat  = 3;
        cpu_addr = 32'h0000_0904;
        cpu_re   = 1'b1;
        for (int i = 0; i < 100 && !mem_re; i++) begin
            @(posedge clk); #1;
        end
        check("rstmid_reached_mack", 32'(mem_re), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_mem_re", 32'(mem_re), 32'd0);
        check("rstmid_cpu_rack", 32'(cpu_rack), 32'd0);
`ifdef ICACHE_STAT_EN
        check("rstmid_hit_cnt", hit_cnt, 32'd0);
        check("rstmid_miss_cnt", miss_cnt, 32'd0);
`endif
        cpu_re = 1'b0;
        rst = 1'b0;
        clear_model();
        m_hits = 0;
        m_miss = 0;
        repeat (12) @(posedge clk);
        #1;
        mmu_lat = 2;
        fetch(32'h0000_0904, 1'b0, 1'b0);
        fetch(32'h0000_090C, 1'b1, 1'b0);
        check("final_dout", cpu_dout, 32'hA5A5_ACA9);
`ifdef ICACHE_STAT_EN
        check("hit_cnt", hit_cnt, 32'(m_hits));
        check("miss_cnt", miss_cnt, 32'(m_miss));
`endif
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
